// File: rtl/dmem_store_buffer_if.sv
// Bundle between the MEM stage / Dmem side (master) and the store buffer (slave).
// The master drives the request, flush and Dmem read data; the slave drives stall, load result and the Dmem port.
interface dmem_store_buffer_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_memlen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic [31:0] load_data;
    logic        buf_empty;
    logic        dm_we;
    logic [2:0]  dm_memlen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        output req_valid, req_we, req_memlen, req_addr, req_wdata, flush, dm_rdata,
        input  stall, load_data, buf_empty, dm_we, dm_memlen, dm_addr, dm_wdata
    );

    modport slave (
        input  req_valid, req_we, req_memlen, req_addr, req_wdata, flush, dm_rdata,
        output stall, load_data, buf_empty, dm_we, dm_memlen, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store FIFO in front of a single-port Dmem: loads use the port combinationally (zero latency),
// stores retire in order on any cycle the port is free; overlapping loads and flushes are held via stall.
module dmem_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_store_buffer_if.slave bus
);
    localparam logic [2:0] MEMLEN_LW  = 3'd0;
    localparam logic [2:0] MEMLEN_LB  = 3'd1;
    localparam logic [2:0] MEMLEN_LBU = 3'd2;
    localparam logic [2:0] MEMLEN_LH  = 3'd3;
    localparam logic [2:0] MEMLEN_SB  = 3'd4;
    localparam logic [2:0] MEMLEN_SH  = 3'd5;
    localparam logic [2:0] MEMLEN_SW  = 3'd6;
    localparam int         PW         = $clog2(DEPTH);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;
    logic [DEPTH-1:0] ent_vld;
    logic [31:0]     ent_addr  [DEPTH];
    logic [2:0]      ent_len   [DEPTH];
    logic [31:0]     ent_wdata [DEPTH];

    logic is_full, is_empty, flush_act, conflict, load_go, drain, legal_store, enq;
    logic stall_ld, stall_st;
    logic [2:0] ld_size;
    logic [ADDR_WIDTH-1:0] req_a, fwd, bwd;

    function automatic logic [2:0] access_size(input logic [2:0] len);
        case (len)
            MEMLEN_LB, MEMLEN_LBU, MEMLEN_SB: access_size = 3'd1;
            MEMLEN_LH, MEMLEN_SH:             access_size = 3'd2;
            default:                          access_size = 3'd4;
        endcase
    endfunction

    assign ld_size = access_size(bus.req_memlen);

    // Two byte ranges overlap iff either start lies inside the other range; modular
    // differences keep this correct across word and address-space boundaries.
    always_comb begin
        conflict = 1'b0;
        req_a    = bus.req_addr[ADDR_WIDTH-1:0];
        fwd      = '0;
        bwd      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd = ent_addr[i][ADDR_WIDTH-1:0] - req_a;
            bwd = req_a - ent_addr[i][ADDR_WIDTH-1:0];
            if (ent_vld[i] && ((fwd < ADDR_WIDTH'(ld_size)) ||
                               (bwd < ADDR_WIDTH'(access_size(ent_len[i])))))
                conflict = 1'b1;
        end
    end

    assign is_full     = (count == (PW+1)'(DEPTH));
    assign is_empty    = (count == '0);
    // An empty buffer has nothing to flush, so requests flow normally.
    assign flush_act   = bus.flush & ~is_empty;
    assign legal_store = (bus.req_memlen == MEMLEN_SB) || (bus.req_memlen == MEMLEN_SH) ||
                         (bus.req_memlen == MEMLEN_SW);

    assign load_go  = ~rst & bus.req_valid & ~bus.req_we & ~flush_act & ~conflict & ~is_full;
    assign drain    = ~rst & ~is_empty & ~load_go;
    assign stall_ld = bus.req_valid & ~bus.req_we & ~load_go;
    assign stall_st = bus.req_valid & bus.req_we & ((is_full & ~drain) | flush_act);
    assign enq      = ~rst & bus.req_valid & bus.req_we & ~stall_st & ~flush_act & legal_store;

    assign bus.stall     = ~rst & (stall_ld | stall_st);
    assign bus.buf_empty = rst | is_empty;
    assign bus.load_data = load_go ? bus.dm_rdata : 32'd0;
    assign bus.dm_we     = drain;
    assign bus.dm_addr   = drain ? ent_addr[head]  : bus.req_addr;
    assign bus.dm_memlen = drain ? ent_len[head]   : bus.req_memlen;
    assign bus.dm_wdata  = drain ? ent_wdata[head] : bus.req_wdata;

    // Drain clears its valid bit before enqueue sets one, so a full-buffer swap onto the old head stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (drain) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (enq) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail]  <= bus.req_addr;
            ent_len[tail]   <= bus.req_memlen;
            ent_wdata[tail] <= bus.req_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized and directed bench for dmem_store_buffer against a queue-based reference model
// and a byte-array Dmem model.
module tb_dmem_store_buffer;
    localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3;
    localparam logic [2:0] SB = 3'd4, SH = 3'd5, SW = 3'd6, BAD = 3'd7;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] data;
    } st_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] ld;
        logic        empty;
        logic        we;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_store_buffer_if bus();

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- Dmem model (written only by the DUT's port) ----------------
    logic [7:0] dmem [512];
    logic       mem_ready = 1'b0;
    logic [8:0] wa, ra;
    assign wa = bus.dm_addr[8:0];
    assign ra = bus.dm_addr[8:0];

    function automatic logic [7:0] init_byte(input logic [8:0] i);
        return i[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) dmem[i] <= init_byte(9'(i));
            mem_ready <= 1'b1;
        end else if (bus.dm_we) begin
            dmem[wa] <= bus.dm_wdata[7:0];
            if (bus.dm_memlen == SH || bus.dm_memlen == SW) dmem[wa + 9'd1] <= bus.dm_wdata[15:8];
            if (bus.dm_memlen == SW) begin
                dmem[wa + 9'd2] <= bus.dm_wdata[23:16];
                dmem[wa + 9'd3] <= bus.dm_wdata[31:24];
            end
        end
    end

    always_comb begin
        case (bus.dm_memlen)
            LW:      bus.dm_rdata = {dmem[ra + 9'd3], dmem[ra + 9'd2], dmem[ra + 9'd1], dmem[ra]};
            LH:      bus.dm_rdata = {{16{dmem[ra + 9'd1][7]}}, dmem[ra + 9'd1], dmem[ra]};
            LB:      bus.dm_rdata = {{24{dmem[ra][7]}}, dmem[ra]};
            LBU:     bus.dm_rdata = {24'd0, dmem[ra]};
            default: bus.dm_rdata = 32'd0;
        endcase
    end

    // ---------------- Reference model ----------------
    st_t        pend [$];
    logic [7:0] model_mem [512];  // what Dmem should hold
    logic [7:0] arch_mem  [512];  // program-order view including pending stores
    resp_t      exp_r, obs_r;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic int size_of(input logic [2:0] len);
        if (len == LB || len == LBU || len == SB) return 1;
        if (len == LH || len == SH) return 2;
        return 4;
    endfunction

    function automatic bit is_store(input logic [2:0] len);
        return len == SB || len == SH || len == SW;
    endfunction

    function automatic bit overlaps(input logic [31:0] a, input logic [2:0] la,
                                    input logic [31:0] b, input logic [2:0] lb);
        for (int i = 0; i < size_of(la); i++)
            for (int j = 0; j < size_of(lb); j++)
                if (a + 32'(i) == b + 32'(j)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] read_arch(input logic [31:0] addr, input logic [2:0] len);
        logic [8:0] x;
        x = addr[8:0];
        case (len)
            LW:      return {arch_mem[x + 9'd3], arch_mem[x + 9'd2], arch_mem[x + 9'd1], arch_mem[x]};
            LH:      return {{16{arch_mem[x + 9'd1][7]}}, arch_mem[x + 9'd1], arch_mem[x]};
            LB:      return {{24{arch_mem[x][7]}}, arch_mem[x]};
            LBU:     return {24'd0, arch_mem[x]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply_store(input st_t s, input bit to_arch);
        logic [8:0] idx;
        for (int k = 0; k < size_of(s.len); k++) begin
            idx = s.addr[8:0] + 9'(k);
            if (to_arch) arch_mem[idx] = s.data[8*k +: 8];
            else         model_mem[idx] = s.data[8*k +: 8];
        end
    endtask

    // Drives one cycle, records expected and observed responses, then advances the model at the edge.
    task automatic cycle(input logic v, input logic we, input logic [2:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic fl, input logic rs);
        bit empty, full, fact, conf, go, drn, stl;
        st_t s;
        @(negedge clk);
        rst = rs;
        bus.req_valid = v; bus.req_we = we; bus.req_memlen = len;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.flush = fl;
        empty = (pend.size() == 0);
        full  = (pend.size() == DEPTH);
        fact  = fl && !empty;
        conf  = 1'b0;
        foreach (pend[i]) if (overlaps(addr, len, pend[i].addr, pend[i].len)) conf = 1'b1;
        go  = !rs && v && !we && !fact && !conf && !full;
        drn = !rs && !empty && !go;
        stl = !rs && v && (we ? ((full && !drn) || fact) : !go);
        exp_r.stall = stl;
        exp_r.ld    = go ? read_arch(addr, len) : 32'd0;
        exp_r.empty = rs || empty;
        exp_r.we    = drn;
        exp_r.len   = drn ? pend[0].len  : len;
        exp_r.addr  = drn ? pend[0].addr : addr;
        exp_r.wdata = drn ? pend[0].data : 32'd0;
        #1;
        obs_r.stall = bus.stall;
        obs_r.ld    = bus.load_data;
        obs_r.empty = bus.buf_empty;
        obs_r.we    = bus.dm_we;
        obs_r.len   = bus.dm_memlen;
        obs_r.addr  = bus.dm_addr;
        obs_r.wdata = bus.dm_we ? bus.dm_wdata : 32'd0;
        @(posedge clk);
        if (rs) begin
            pend.delete();
            arch_mem = model_mem;
        end else begin
            if (drn) begin
                apply_store(pend[0], 1'b0);
                void'(pend.pop_front());
            end
            if (v && we && !stl && is_store(len)) begin
                s.addr = addr; s.len = len; s.data = wdata;
                pend.push_back(s);
                apply_store(s, 1'b1);
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, LW, 32'h0, 32'h0, 1'b0, i < 2);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
    endtask

    task automatic test_store_drain;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cycle(1'b1, 1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
            else        cycle(1'b0, 1'b0, LW, 32'h0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL store_drain c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
    endtask

    task automatic test_overlap;
        int stalls = 0;
        int n = 0;
        cycle(1'b1, 1'b1, SW, 32'h20, 32'h11223344, 1'b0, 1'b0);
        vectors++;
        if (obs_r !== exp_r) begin
            miscompares++;
            $display("FAIL overlap_sw: got %h want %h", obs_r, exp_r);
        end
        do begin
            cycle(1'b1, 1'b0, LB, 32'h22, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL overlap_lb c%0d: got %h want %h", n, obs_r, exp_r);
            end
            if (obs_r.stall) stalls++;
            n++;
        end while (obs_r.stall && n < 6);
        vectors++;
        if (stalls !== 1) begin
            miscompares++;
            $display("FAIL overlap_stall_cycles: got %0d want 1", stalls);
        end
        vectors++;
        if (obs_r.ld !== 32'h00000022) begin
            miscompares++;
            $display("FAIL overlap_data: got %h want 00000022", obs_r.ld);
        end
    endtask

    task automatic test_nonoverlap;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       cycle(1'b1, 1'b1, SB, 32'h40, 32'h000000AA, 1'b0, 1'b0);
                1:       cycle(1'b1, 1'b0, LW, 32'h44, 32'h0, 1'b0, 1'b0);
                default: cycle(1'b0, 1'b0, LW, 32'h0, 32'h0, 1'b0, 1'b0);
            endcase
            vectors++;
            if (obs_r !== exp_r || (i == 1 && obs_r.stall !== 1'b0)) begin
                miscompares++;
                $display("FAIL nonoverlap c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
    endtask

    task automatic test_fill;
        int bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8 && i % 2 == 0)
                cycle(1'b1, 1'b1, SH, 32'h60 + 32'(i), $urandom, 1'b0, 1'b0);
            else if (i < 9)
                cycle(1'b1, 1'b0, LW, 32'h100, 32'h0, 1'b0, 1'b0);
            else
                cycle(1'b0, 1'b0, LW, 32'h0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL fill c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
        for (int a = 32'h60; a < 32'h68; a++) if (dmem[a] !== model_mem[a]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL fill_mem: got %0d bad bytes want 0", bad);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 9; i++) begin
            if (i < 3)      cycle(1'b1, 1'b1, SW, 32'h80 + 32'(4*i), $urandom, 1'b0, 1'b0);
            else if (i < 7) cycle(1'b1, 1'b0, LW, 32'h80, 32'h0, 1'b1, 1'b0);
            else            cycle(1'b1, 1'b1, SW, 32'h8C, 32'hCAFEF00D, 1'b1, 1'b0);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL flush c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) begin
            if (i < 2)      cycle(1'b1, 1'b1, SW, 32'h90 + 32'(4*i), $urandom, 1'b0, 1'b0);
            else if (i < 4) cycle(1'b1, 1'b1, SW, 32'h98, 32'h12345678, 1'b0, 1'b1);
            else            cycle(1'b1, 1'b0, LW, 32'h90, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
    endtask

    task automatic test_random;
        logic v, we, fl, rs;
        logic [2:0] len;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            if (we && $urandom_range(0, 9) != 0) len = 3'(SB + 3'($urandom_range(0, 2)));
            else                                 len = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 59) == 0);
            cycle(v, we, len, 32'h180 + 32'($urandom_range(0, 48)), $urandom, fl, rs);
            vectors++;
            if (obs_r !== exp_r) begin
                miscompares++;
                $display("FAIL random c%0d: got %h want %h", i, obs_r, exp_r);
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, LW, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int a = 0; a < 512; a++) if (dmem[a] !== model_mem[a]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL random_mem: got %0d bad bytes want 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_memlen = LW;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.flush = 1'b0;
        for (int i = 0; i < 512; i++) begin
            model_mem[i] = init_byte(9'(i));
            arch_mem[i]  = init_byte(9'(i));
        end
        test_reset();
        test_store_drain();
        test_overlap();
        test_nonoverlap();
        test_fill();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
